// File: rtl/conv_channel_accumulator_pkg.sv
// Shared types and helpers for the channel accumulator: FSM encoding and the
// counter-width helper used to derive PIX/CIN/COUT counter widths.
package conv_channel_accumulator_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Width needed to index n entries; never less than 1 so single-entry counters stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_channel_accumulator_ram.sv
// Simple dual-port accumulation buffer with a one-cycle registered read.
module conv_acc_ram #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_channel_accumulator.sv
// Channel-reduction stage: sums CHANNEL_NUM_IN partial planes per output channel,
// with stride-2 decimation and saturation. Optional ReLU via CONV_ACC_RELU_EN.
module conv_channel_accumulator
    import conv_channel_accumulator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned ACC_WIDTH       = 32,
    parameter int unsigned IMAGE_WIDTH     = 32,
    parameter int unsigned IMAGE_HEIGHT    = 32,
    parameter int unsigned CHANNEL_NUM_IN  = 512,
    parameter int unsigned CHANNEL_NUM_OUT = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stride2,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned PLANE_MAX      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned PIX_CNT_WIDTH  = clog2(PLANE_MAX);
    localparam int unsigned CIN_CNT_WIDTH  = clog2(CHANNEL_NUM_IN);
    localparam int unsigned COUT_CNT_WIDTH = clog2(CHANNEL_NUM_OUT);

    localparam logic [PIX_CNT_WIDTH-1:0]  PIX_MAX_FULL = PIX_CNT_WIDTH'(PLANE_MAX - 1);
    localparam logic [PIX_CNT_WIDTH-1:0]  PIX_MAX_HALF = PIX_CNT_WIDTH'(PLANE_MAX / 4 - 1);
    localparam logic [CIN_CNT_WIDTH-1:0]  CIN_LAST     = CIN_CNT_WIDTH'(CHANNEL_NUM_IN - 1);
    localparam logic [COUT_CNT_WIDTH-1:0] COUT_LAST    = COUT_CNT_WIDTH'(CHANNEL_NUM_OUT - 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        $signed({{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    state, state_next;
    logic                      stride_q, stride_eff;
    logic [PIX_CNT_WIDTH-1:0]  pix;
    logic [CIN_CNT_WIDTH-1:0]  cin;
    logic [COUT_CNT_WIDTH-1:0] cout;
    logic                      pix_last, cin_last, cout_last, frame_last;

    logic                         s1_valid, s1_first, s1_last, s1_done;
    logic [PIX_CNT_WIDTH-1:0]     s1_pix;
    logic signed [DATA_WIDTH-1:0] s1_data;
    logic [ACC_WIDTH-1:0]         rd_data;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0]        sat_val, result;

    // The first beat of a frame is processed with the live stride2, later beats with the latched copy.
    assign stride_eff = (state == ST_IDLE) ? stride2 : stride_q;
    assign pix_last   = (pix == (stride_eff ? PIX_MAX_HALF : PIX_MAX_FULL));
    assign cin_last   = (cin == CIN_LAST);
    assign cout_last  = (cout == COUT_LAST);
    assign frame_last = valid_in && pix_last && cin_last && cout_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (valid_in && !frame_last) state_next = ST_RUN;
            ST_RUN:  if (frame_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix      <= '0;
            cin      <= '0;
            cout     <= '0;
            stride_q <= 1'b0;
        end else if (valid_in) begin
            if (state == ST_IDLE) stride_q <= stride2;
            if (pix_last) begin
                pix <= '0;
                if (cin_last) begin
                    cin  <= '0;
                    cout <= cout_last ? '0 : cout + 1'b1;
                end else begin
                    cin <= cin + 1'b1;
                end
            end else begin
                pix <= pix + 1'b1;
            end
        end
    end

    conv_acc_ram #(
        .DEPTH      (PLANE_MAX),
        .WIDTH      (ACC_WIDTH),
        .ADDR_WIDTH (PIX_CNT_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (s1_valid && !s1_last),
        .wr_addr (s1_pix),
        .wr_data (sum),
        .rd_en   (valid_in && (cin != '0)),
        .rd_addr (pix),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_done  <= 1'b0;
            s1_pix   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= valid_in;
            s1_first <= (cin == '0);
            s1_last  <= cin_last;
            s1_done  <= frame_last;
            s1_pix   <= pix;
            s1_data  <= $signed(pxl_in);
        end
    end

    // First channel ignores the stale buffer word so the buffer never needs clearing.
    assign sum = (s1_first ? '0 : $signed(rd_data)) + ACC_WIDTH'(s1_data);

    always_comb begin
        if (sum > SAT_MAX)      sat_val = SAT_MAX[DATA_WIDTH-1:0];
        else if (sum < SAT_MIN) sat_val = SAT_MIN[DATA_WIDTH-1:0];
        else                    sat_val = sum[DATA_WIDTH-1:0];
`ifdef CONV_ACC_RELU_EN
        result = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
        result = sat_val;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid_out  <= s1_valid && s1_last;
            frame_done <= s1_valid && s1_last && s1_done;
            if (s1_valid && s1_last) pxl_out <= result;
            if (valid_in && state == ST_IDLE)      busy <= 1'b1;
            else if (s1_valid && s1_last && s1_done) busy <= 1'b0;
        end
    end

endmodule

// File: doc/conv_channel_accumulator.md
# conv_channel_accumulator

Parametrised channel-reduction stage for the 3x3/dilated convolution path. It sits directly after the per-channel convolution core. It sums CHANNEL_NUM_IN partial-product planes into one output plane per output channel, using an on-chip accumulation buffer. It generalises the fixed 512-channel adder to any channel count and image size, adds stride-2 output decimation, saturating output, a frame-done flag and optional ReLU.

## Interface
Parameters:
- DATA_WIDTH, 16: signed fixed-point width of pxl_in/pxl_out
- ACC_WIDTH, 32: accumulator width; must be ≥ DATA_WIDTH + clog2(CHANNEL_NUM_IN)
- IMAGE_WIDTH, 32: plane width before decimation (even)
- IMAGE_HEIGHT, 32: plane height before decimation (even)
- CHANNEL_NUM_IN, 512: planes summed per output channel (≥1)
- CHANNEL_NUM_OUT, 512: output channels per frame (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- stride2  in  1  1 = plane is (IMAGE_WIDTH/2)x(IMAGE_HEIGHT/2) pixels; sampled at frame start
- valid_in  in  1  pxl_in qualifier, one partial sum per cycle, no backpressure
- pxl_in  in  DATA_WIDTH  signed partial sum
- pxl_out  out  DATA_WIDTH  signed saturated channel sum
- valid_out  out  1  pxl_out qualifier
- busy  out  1  high from first accepted beat of a frame until frame_done
- frame_done  out  1  one-cycle pulse with the last valid_out of the frame

## Operation
- Input order, channel-major: for each ch_out, for each ch_in, PLANE pixels in raster order. PLANE = W*H, or W*H/4 when stride2 is set.
- Counters: pix (0..PLANE-1), cin (0..CHANNEL_NUM_IN-1), cout (0..CHANNEL_NUM_OUT-1). They advance only on valid_in, nested pix → cin → cout, and each wraps to 0.
- Frame state, 2 states:
  - IDLE: busy=0; stride2 is latched on the first valid_in, which is also processed.
  - RUN: entered on that beat; returns to IDLE on the beat where pix, cin and cout are all at maximum.
- Per beat, by channel:
  - cin==0: buffer[pix] ← sign-extend(pxl_in). No read is used.
  - 0<cin<last: buffer[pix] ← buffer[pix] + pxl_in, wrapping in ACC_WIDTH.
  - cin==last: sum = buffer[pix] + pxl_in. The buffer write is not required. Output = sat(sum) to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- CHANNEL_NUM_IN==1: every beat is both first and last; output = pxl_in.
- Read-modify-write hazard: the same address recurs only PLANE beats later, and PLANE ≥ 4, so no forwarding is needed for the 2-stage pipeline. The implementation must still be correct with back-to-back valid_in.
- stride2 changes during RUN are ignored until the next IDLE.
- Buffer contents are never cleared. They are fully overwritten by cin==0.

## Timing
- Latency: valid_out is asserted 2 cycles after the valid_in beat with cin==last (read in cycle t, add/saturate in t+1, registered output in t+2).
- One output per last-channel input beat; output gaps mirror input gaps.
- frame_done is coincident with the final valid_out. busy falls in the same cycle.
- Reset values: pxl_out=0, valid_out=0, busy=0, frame_done=0, all counters 0, state IDLE.
- Reset mid-frame: in-flight pipeline beats are discarded (no valid_out after reset). The next valid_in starts a new frame at pix=cin=cout=0.

## Configuration
- CONV_ACC_RELU_EN defined: pxl_out = max(0, sat(sum)), applied after saturation with no added latency.
- CONV_ACC_RELU_EN undefined: pxl_out = sat(sum), with negative values passed through.

## Structure
- Shared parameter include/package holds the clog2 helper and the derived constants PLANE_MAX = W*H, PIX_CNT_WIDTH, CIN_CNT_WIDTH, COUT_CNT_WIDTH, and the saturation min/max constants.
- Sub-module conv_acc_ram:
  - simple dual-port RAM, depth PLANE_MAX, width ACC_WIDTH
  - 1-cycle registered read
  - write-first not required

## Test plan
Bench parameters: W=H=4, CIN=3, COUT=2, DATA_WIDTH=16, ACC_WIDTH=24.
- All pxl_in=1, stride2=0, continuous valid → 32 outputs of 3. frame_done and busy fall with the 32nd output. Each output comes 2 cycles after its cin=2 beat.
- pxl_in = pix + 16*cin + 100*cout → outputs 3*pix+48+300*cout (e.g. cout=1, pix=5: 363).
- pxl_in=0x7FFF on all beats → 0x7FFF. Then pxl_in=0x8000 → 0x8000, or 0 with CONV_ACC_RELU_EN.
- stride2=1 → 8 outputs total (4 per cout). Toggling stride2 mid-frame has no effect. The next frame honours the new value.
- Random idle gaps on valid_in → identical output sequence to the gap-free case, with frame_done on the last output.
- Assert reset after 20 beats, then a full frame of pxl_in=−5 → no stale valid_out. Outputs are −15, or 0 with CONV_ACC_RELU_EN.
